// File: rtl/imu_pkg.sv
// Shared types and constants for the inertial sensor reader.
//   state_t   : top-level sequencing FSM states
//   ADDR_*    : IMU data register addresses (read-form byte values)
//   CFG_WORDS : configuration writes issued once after reset, index 0 first
//   rd_cmd    : builds a 16-bit SPI read command for a register address
//   addr_of   : maps a read state to the register it fetches
package imu_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT,
    CFG,
    IDLE,
    RD_PL,
    RD_PH,
    RD_AZL,
    RD_AZH,
    DONE
  } state_t;

  localparam logic [7:0] ADDR_PITCH_L = 8'hA2;
  localparam logic [7:0] ADDR_PITCH_H = 8'hA3;
  localparam logic [7:0] ADDR_AZ_L    = 8'hAC;
  localparam logic [7:0] ADDR_AZ_H    = 8'hAD;

  localparam int unsigned NUM_CFG = 4;
  localparam int unsigned CFG_IDX_W = 2;

  // INT enable, accel 208Hz, gyro 208Hz, rounding; index 0 is sent first
  localparam logic [NUM_CFG-1:0][15:0] CFG_WORDS = {
    16'h1460, 16'h1150, 16'h1053, 16'h0D02
  };

  // Only the low 7 address bits travel on the wire; bit 15 is the read flag
  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

  function automatic logic [6:0] addr_of(input state_t st);
    logic [6:0] a;
    a = ADDR_PITCH_L[6:0];
    case (st)
      RD_PL:   a = ADDR_PITCH_L[6:0];
      RD_PH:   a = ADDR_PITCH_H[6:0];
      RD_AZL:  a = ADDR_AZ_L[6:0];
      RD_AZH:  a = ADDR_AZ_H[6:0];
      default: a = ADDR_PITCH_L[6:0];
    endcase
    return a;
  endfunction

endpackage

// File: rtl/imu_spi_master.sv
// SPI mode-3 master, one 16-bit frame per wrt pulse.
//   clk, rst  : clock, synchronous active-high reset
//   wrt, cmd  : start a frame shifting out cmd, MSB first
//   done      : one-cycle pulse once the frame and the inter-frame gap are over
//   rd_data   : the 16 MISO bits of the last frame
//   SS_n, SCLK, MOSI, MISO : IMU pins (SCLK idles high)
module imu_spi_master #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  localparam int unsigned HALF  = SCLK_DIV / 2;
  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BIT_W = 5;

  typedef enum logic [2:0] {
    P_IDLE,
    P_FRONT,
    P_LOW,
    P_HIGH,
    P_GAP
  } phase_t;

  phase_t             phase;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [15:0]        shreg;
  logic               div_last;

  assign div_last = (div_cnt == DIV_W'(HALF - 1));

  // Each non-idle phase lasts HALF clks; the high half after the 16th rise
  // doubles as the back porch.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= P_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rd_data <= '0;
      done    <= 1'b0;
      SS_n    <= 1'b1;
      SCLK    <= 1'b1;
      MOSI    <= 1'b0;
    end else begin
      done    <= 1'b0;
      div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
      case (phase)
        P_IDLE: begin
          div_cnt <= '0;
          if (wrt) begin
            SS_n    <= 1'b0;
            shreg   <= cmd;
            bit_cnt <= '0;
            phase   <= P_FRONT;
          end
        end
        P_FRONT: begin
          if (div_last) begin
            SCLK  <= 1'b0;
            MOSI  <= shreg[15];
            phase <= P_LOW;
          end
        end
        P_LOW: begin
          // Rising edge: sample MISO into the vacated LSB
          if (div_last) begin
            SCLK    <= 1'b1;
            shreg   <= {shreg[14:0], MISO};
            bit_cnt <= bit_cnt + BIT_W'(1);
            phase   <= P_HIGH;
          end
        end
        P_HIGH: begin
          if (div_last) begin
            if (bit_cnt == BIT_W'(16)) begin
              SS_n    <= 1'b1;
              MOSI    <= 1'b0;
              rd_data <= shreg;
              phase   <= P_GAP;
            end else begin
              SCLK  <= 1'b0;
              MOSI  <= shreg[15];
              phase <= P_LOW;
            end
          end
        end
        P_GAP: begin
          if (div_last) begin
            done  <= 1'b1;
            phase <= P_IDLE;
          end
        end
        default: phase <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/inertial_sensor_reader.sv
// IMU front end: configures the IMU over SPI, then on each data-ready
// interrupt reads pitch rate and Z acceleration and presents them together.
//   clk, rst   : clock, synchronous active-high reset
//   INT        : asynchronous IMU data-ready level
//   MISO/SS_n/SCLK/MOSI : SPI pins
//   vld        : one-cycle strobe when ptch_rt/AZ update
//   ptch_rt, AZ: signed raw samples, held between strobes
//   init_done  : high once configuration has completed
module inertial_sensor_reader
  import imu_pkg::*;
#(
  parameter int unsigned SCLK_DIV      = 32,
  parameter int unsigned INIT_WAIT_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        init_done
);

  localparam int unsigned CNT_W = $clog2(INIT_WAIT_CYC + 1);

  state_t               state;
  logic [CNT_W-1:0]     init_cnt;
  logic [CFG_IDX_W-1:0] cfg_idx;
  logic                 busy;
  logic                 wrt;
  logic [15:0]          cmd;
  logic                 int_meta;
  logic                 int_s;
  logic [7:0]           pl, ph, azl, azh;
  logic                 spi_done;
  logic [15:0]          spi_rd_data;
  logic [7:0]           rd_byte;
  logic [7:0]           unused_rd_hi;

  // Command echo bits of a read frame carry no data
  assign rd_byte      = spi_rd_data[7:0];
  assign unused_rd_hi = spi_rd_data[15:8];

  imu_spi_master #(
    .SCLK_DIV (SCLK_DIV)
  ) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (MISO),
    .done    (spi_done),
    .rd_data (spi_rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI)
  );

  // INT synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta <= 1'b0;
      int_s    <= 1'b0;
    end else begin
      int_meta <= INT;
      int_s    <= int_meta;
    end
  end

  // Sequencer; busy marks a frame issued and awaiting spi_done. Bytes land in
  // holding registers so the outputs only ever change together on vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_WAIT;
      init_cnt  <= '0;
      cfg_idx   <= '0;
      busy      <= 1'b0;
      wrt       <= 1'b0;
      cmd       <= '0;
      pl        <= '0;
      ph        <= '0;
      azl       <= '0;
      azh       <= '0;
      vld       <= 1'b0;
      ptch_rt   <= '0;
      AZ        <= '0;
      init_done <= 1'b0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        INIT_WAIT: begin
          if (init_cnt == CNT_W'(INIT_WAIT_CYC - 1)) begin
            state   <= CFG;
            cfg_idx <= '0;
            busy    <= 1'b0;
          end else begin
            init_cnt <= init_cnt + CNT_W'(1);
          end
        end
        CFG: begin
          if (!busy) begin
            wrt  <= 1'b1;
            cmd  <= CFG_WORDS[cfg_idx];
            busy <= 1'b1;
          end else if (spi_done) begin
            busy <= 1'b0;
            if (cfg_idx == CFG_IDX_W'(NUM_CFG - 1)) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              cfg_idx <= cfg_idx + CFG_IDX_W'(1);
            end
          end
        end
        IDLE: begin
          if (int_s) state <= RD_PL;
        end
        RD_PL, RD_PH, RD_AZL, RD_AZH: begin
          if (!busy) begin
            wrt  <= 1'b1;
            cmd  <= rd_cmd(addr_of(state));
            busy <= 1'b1;
          end else if (spi_done) begin
            busy <= 1'b0;
            case (state)
              RD_PL:   begin pl  <= rd_byte; state <= RD_PH;  end
              RD_PH:   begin ph  <= rd_byte; state <= RD_AZL; end
              RD_AZL:  begin azl <= rd_byte; state <= RD_AZH; end
              default: begin azh <= rd_byte; state <= DONE;   end
            endcase
          end
        end
        DONE: begin
          ptch_rt <= {ph, pl};
          AZ      <= {azh, azl};
          vld     <= 1'b1;
          state   <= IDLE;
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inertial_sensor_reader.sv
// Scoreboard bench for inertial_sensor_reader with an SPI slave model on the pins.
module tb_inertial_sensor_reader;

  localparam int unsigned SCLK_DIV      = 8;
  localparam int unsigned INIT_WAIT_CYC = 64;
  localparam int          LIMIT         = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, vld, init_done;
  logic [15:0] ptch_rt, AZ;

  always #5 clk = ~clk;

  inertial_sensor_reader #(
    .SCLK_DIV      (SCLK_DIV),
    .INIT_WAIT_CYC (INIT_WAIT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .MISO      (MISO),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .vld       (vld),
    .ptch_rt   (ptch_rt),
    .AZ        (AZ),
    .init_done (init_done)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_cmd [$];
  logic [7:0]  resp_q  [$];
  logic [31:0] exp_out [$];

  int frames_done = 0;
  int aborted     = 0;
  int vld_cnt     = 0;
  int chg_err     = 0;
  int slave_bits  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_ge(input string name, input int act, input int min);
    tests++;
    if (act < min) begin
      fails++;
      $display("FAIL %s: got %0d, expected >= %0d", name, act, min);
    end
  endfunction

  // SPI slave model: mode 3, sampled on the falling clk edge
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  logic [15:0] tx = '0;
  logic [15:0] rx = '0;
  logic [15:0] e_cmd;
  int          hi_cnt = 0;

  always @(negedge clk) begin
    if (prev_ss && !SS_n) begin
      check_ge("ss_gap", hi_cnt, SCLK_DIV / 2);
      tx = 16'h0000;
      if (resp_q.size() > 0) tx[7:0] = resp_q.pop_front();
      rx = '0;
      slave_bits = 0;
    end else if (!prev_ss && SS_n) begin
      if (slave_bits == 16) begin
        frames_done++;
        if (exp_cmd.size() == 0) begin
          check("spi_cmd_unexpected", 32'(rx), 32'hFFFF_FFFF);
        end else begin
          e_cmd = exp_cmd.pop_front();
          check("spi_cmd", 32'(rx), 32'(e_cmd));
        end
      end else begin
        aborted++;
      end
    end else if (!SS_n) begin
      if (prev_sclk && !SCLK) begin
        MISO = tx[15];
        tx   = {tx[14:0], 1'b0};
      end else if (!prev_sclk && SCLK) begin
        rx = {rx[14:0], MOSI};
        slave_bits++;
      end
    end
    hi_cnt    = SS_n ? hi_cnt + 1 : 0;
    prev_ss   = SS_n;
    prev_sclk = SCLK;
  end

  // Output monitor: pop expected pair on every vld, watch for stray changes
  logic        prev_vld = 1'b0;
  logic [15:0] last_p = '0;
  logic [15:0] last_a = '0;
  logic [31:0] e_out;

  always @(negedge clk) begin
    if (vld) begin
      vld_cnt++;
      check("vld_width", 32'(prev_vld), 32'd0);
      if (exp_out.size() == 0) begin
        check("vld_unexpected", {ptch_rt, AZ}, 32'hFFFF_FFFF);
      end else begin
        e_out = exp_out.pop_front();
        check("ptch_rt", 32'(ptch_rt), 32'(e_out[31:16]));
        check("AZ", 32'(AZ), 32'(e_out[15:0]));
      end
    end else if (!rst && (ptch_rt != last_p || AZ != last_a)) begin
      chg_err++;
    end
    prev_vld = vld;
    last_p   = ptch_rt;
    last_a   = AZ;
  end

  task automatic push_cfg();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1053);
    exp_cmd.push_back(16'h1150);
    exp_cmd.push_back(16'h1460);
  endtask

  task automatic push_seq(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    exp_cmd.push_back(16'hAD00);
    resp_q.push_back(b0);
    resp_q.push_back(b1);
    resp_q.push_back(b2);
    resp_q.push_back(b3);
    exp_out.push_back({b1, b0, b3, b2});
  endtask

  task automatic check_quiet(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (SCLK !== 1'b1 || SS_n !== 1'b1) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic wait_init(input string name);
    for (int n = 0; n < LIMIT && !init_done; n++) @(negedge clk);
    check(name, 32'(init_done), 32'd1);
  endtask

  task automatic wait_ss_low(input string name);
    for (int n = 0; n < LIMIT && SS_n; n++) @(negedge clk);
    check(name, 32'(SS_n), 32'd0);
  endtask

  task automatic wait_vld(input string name, input int target);
    for (int n = 0; n < 2 * LIMIT && vld_cnt < target; n++) @(negedge clk);
    check(name, 32'(vld_cnt), 32'(target));
  endtask

  int base_v;
  int base_f;

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(SS_n), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd1);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_ptch", 32'(ptch_rt), 32'd0);
    check("rst_az", 32'(AZ), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    // Configuration writes after the init wait
    push_cfg();
    rst = 1'b0;
    check_quiet("init_quiet");
    check("init_done_early", 32'(init_done), 32'd0);
    wait_init("init_done_wait");
    check("cfg_frames", 32'(frames_done), 32'd4);

    // Single read sequence
    push_seq(8'h34, 8'h12, 8'hCD, 8'hAB);
    INT = 1'b1;
    wait_ss_low("seq1_start");
    INT = 1'b0;
    wait_vld("seq1_vld", 1);
    repeat (300) @(negedge clk);
    check("seq1_single", 32'(vld_cnt), 32'd1);
    check("seq1_hold_ptch", 32'(ptch_rt), 32'h1234);

    // INT held high: back-to-back sequences
    push_seq(8'h11, 8'h22, 8'h33, 8'h44);
    push_seq(8'hFF, 8'h7F, 8'h00, 8'h80);
    INT = 1'b1;
    wait_vld("seq2_vld", 2);
    wait_ss_low("seq3_start");
    INT = 1'b0;
    wait_vld("seq3_vld", 3);
    repeat (700) @(negedge clk);
    check("seq3_count", 32'(vld_cnt), 32'd3);

    // Reset in the middle of the pitch-high read
    base_v = vld_cnt;
    base_f = frames_done;
    exp_cmd.push_back(16'hA200);
    resp_q.push_back(8'h55);
    resp_q.push_back(8'h66);
    INT = 1'b1;
    wait_ss_low("abort_seq_start");
    INT = 1'b0;
    for (int n = 0; n < LIMIT && frames_done < base_f + 1; n++) @(negedge clk);
    check("abort_pl_frame", 32'(frames_done), 32'(base_f + 1));
    for (int n = 0; n < LIMIT && !(!SS_n && slave_bits == 7); n++) @(negedge clk);
    check("abort_bit7", 32'(slave_bits), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss_n", 32'(SS_n), 32'd1);
    repeat (2) @(negedge clk);
    check("abort_ptch", 32'(ptch_rt), 32'd0);
    check("abort_az", 32'(AZ), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_no_vld", 32'(vld_cnt), 32'(base_v));
    check("abort_count", 32'(aborted), 32'd1);
    resp_q.delete();
    push_cfg();
    rst = 1'b0;
    check_quiet("reinit_quiet");
    wait_init("reinit_done");
    check("reinit_frames", 32'(frames_done), 32'(base_f + 5));

    // Short INT pulse during the AZ-low read is ignored
    base_v = vld_cnt;
    base_f = frames_done;
    push_seq(8'h01, 8'h02, 8'h03, 8'h04);
    INT = 1'b1;
    wait_ss_low("pulse_seq_start");
    INT = 1'b0;
    for (int n = 0; n < 2 * LIMIT && frames_done < base_f + 2; n++) @(negedge clk);
    wait_ss_low("azl_start");
    repeat (20) @(negedge clk);
    INT = 1'b1;
    @(negedge clk);
    INT = 1'b0;
    wait_vld("pulse_vld", base_v + 1);
    repeat (800) @(negedge clk);
    check("pulse_single_vld", 32'(vld_cnt), 32'(base_v + 1));
    check("pulse_frames", 32'(frames_done), 32'(base_f + 4));

    // Scoreboard drained, outputs only moved on vld
    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    check("out_queue_empty", 32'(exp_out.size()), 32'd0);
    check("stable_outputs", 32'(chg_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
